viol_reset_seq: RTL and testbench
=================================

# viol_reset_seq

Reset sequencer downstream of the access-control monitors (DMA key-memory monitor and peers). Collects their per-monitor reset requests, drives a single registered system reset to the CPU with a guaranteed minimum assertion width, and supervises release until execution restarts at the reset handler. Also records which monitor(s) caused the most recent violation reset, and keeps a count of such resets for the attestation/debug path.

## Interface
- NUM_SRC, 4: number of monitor reset-request inputs (≥1).
- HOLD_CYCLES, 16: cycles sys_reset stays asserted per reset event (≥1).
- REL_TIMEOUT, 255: max cycles in RELEASE before re-asserting (≥1).
- RESET_HANDLER, 16'h0000: PC value that marks restart at the reset handler.

- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- viol  input  NUM_SRC  level reset requests from monitors; bit i = monitor i.
- pc  input  16  current CPU program counter.
- sys_reset  output  1  registered reset to CPU core.
- cause  output  NUM_SRC  viol bits captured at the last RUN→ASSERT transition.
- cause_valid  output  1  high once any violation-triggered reset has occurred since rst.
- reset_count  output  8  number of RUN→ASSERT transitions since rst, saturating at 255.

## Operation
- States: ASSERT, RELEASE, RUN.
- ASSERT: sys_reset=1; hold counter increments each cycle; after HOLD_CYCLES cycles in ASSERT → RELEASE. viol ignored (does not extend hold, not OR'd into cause).
- RELEASE: sys_reset=0; timeout counter increments. pc==RESET_HANDLER and viol==0 in the same cycle → RUN. Timeout counter reaching REL_TIMEOUT without that → ASSERT (cause/count unchanged). viol high with pc≠RESET_HANDLER: expected (monitors still in their kill state), ignored.
- RUN: sys_reset=0. Any viol bit high → ASSERT; cause ← viol (all simultaneous bits captured), cause_valid ← 1, reset_count ← min(reset_count+1, 255).
- Counters cleared on every entry to ASSERT and to RELEASE.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(REL_TIMEOUT+1) bits; no wrap.

## Timing
- rst asserted: immediately (async) state=ASSERT, sys_reset=1, counters=0, cause=0, cause_valid=0, reset_count=0.
- rst deasserted: behaves as entry to ASSERT; first RELEASE cycle follows HOLD_CYCLES edges later.
- viol sampled high in RUN at edge n → sys_reset=1 after edge n (one-cycle latency); cause/count update on the same edge.
- sys_reset high for exactly HOLD_CYCLES consecutive cycles per ASSERT visit.
- RELEASE→RUN takes effect on the edge where the condition is sampled; viol sampled in the first RUN cycle is acted on normally.
- rst mid-ASSERT/RELEASE/RUN: full reset as above; cause and count are lost.

## Structure
- Shared package: state enum (ASSERT, RELEASE, RUN), RESET_HANDLER default, reset_count width constant.
- One sub-module: hold_timer — clearable up-counter with terminal-count flag, instanced twice (hold, release timeout).
- Everything else in one always_ff FSM plus registered outputs; no combinational path from viol to sys_reset.

## Test plan
- rst pulse, HOLD_CYCLES=16, pc=0, viol=0 → sys_reset high 16 cycles after rst release, RUN on next edge; cause=0, cause_valid=0, reset_count=0.
- In RUN drive viol=4'b0100 for 1 cycle → sys_reset=1 next cycle for 16 cycles; cause=4'b0100, cause_valid=1, reset_count=1.
- In RUN drive viol=4'b1001 same cycle → cause=4'b1001, reset_count increments by exactly 1.
- viol pulses during ASSERT → hold length still 16, cause unchanged.
- RELEASE with pc stuck at 16'h4400, REL_TIMEOUT=255 → after 255 cycles sys_reset re-asserts; reset_count unchanged.
- Force 300 violations → reset_count saturates at 255; rst asserted mid-RELEASE → sys_reset=1 immediately, all outputs zeroed.

Source files
------------

// File: rtl/viol_reset_seq_pkg.sv
// rtl/viol_reset_seq_pkg.sv - shared types and constants for the violation reset sequencer
package viol_reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;
   localparam int          COUNT_W           = 8;
   localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

endpackage

// File: rtl/viol_reset_seq_hold_timer.sv
// rtl/viol_reset_seq_hold_timer.sv - clearable saturating up-counter with last-cycle flag
module viol_reset_seq_hold_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);
   localparam logic [W-1:0] TOP  = W'(LIMIT);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != TOP)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // High during the LIMIT-th cycle since clear, so the state leaves on that edge.
   assign o_tc = (r_count == LAST);

endmodule

// File: rtl/viol_reset_seq.sv
// rtl/viol_reset_seq.sv - collects monitor reset requests and sequences the CPU system reset
module viol_reset_seq
   import viol_reset_seq_pkg::*;
#(
   parameter int          NUM_SRC       = 4,
   parameter int          HOLD_CYCLES   = 16,
   parameter int          REL_TIMEOUT   = 255,
   parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] viol,
   input  logic [15:0]        pc,
   output logic               sys_reset,
   output logic [NUM_SRC-1:0] cause,
   output logic               cause_valid,
   output logic [COUNT_W-1:0] reset_count
);

   state_t r_state;
   state_t w_next;

   logic               r_sys_reset;
   logic               w_sys_reset_nxt;
   logic [NUM_SRC-1:0] r_cause;
   logic               r_cause_valid;
   logic [COUNT_W-1:0] r_reset_count;

   logic w_hold_tc;
   logic w_rel_tc;
   logic w_in_assert;
   logic w_in_release;
   logic w_any_viol;
   logic w_rel_ok;

   assign w_in_assert  = (r_state == ST_ASSERT);
   assign w_in_release = (r_state == ST_RELEASE);
   assign w_any_viol   = |viol;
   assign w_rel_ok     = (pc == RESET_HANDLER) && (viol == '0);

   // Timers sit cleared outside their state, so every entry starts from zero.
   viol_reset_seq_hold_timer #(.LIMIT(HOLD_CYCLES)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_in_assert),
      .i_en  (w_in_assert),
      .o_tc  (w_hold_tc)
   );

   viol_reset_seq_hold_timer #(.LIMIT(REL_TIMEOUT)) u_rel (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_in_release),
      .i_en  (w_in_release),
      .o_tc  (w_rel_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ASSERT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_ASSERT: begin
            if (w_hold_tc) w_next = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (w_rel_ok)      w_next = ST_RUN;
            else if (w_rel_tc) w_next = ST_ASSERT;
         end
         ST_RUN: begin
            if (w_any_viol) w_next = ST_ASSERT;
         end
         default: w_next = ST_ASSERT;
      endcase
   end

   always_comb begin
      w_sys_reset_nxt = (w_next == ST_ASSERT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sys_reset   <= 1'b1;
         r_cause       <= '0;
         r_cause_valid <= 1'b0;
         r_reset_count <= '0;
      end else begin
         r_sys_reset <= w_sys_reset_nxt;
         if ((r_state == ST_RUN) && w_any_viol) begin
            r_cause       <= viol;
            r_cause_valid <= 1'b1;
            if (r_reset_count != COUNT_MAX) r_reset_count <= r_reset_count + 1'b1;
         end
      end
   end

   assign sys_reset   = r_sys_reset;
   assign cause       = r_cause;
   assign cause_valid = r_cause_valid;
   assign reset_count = r_reset_count;

endmodule

// File: tb/tb_viol_reset_seq.sv
// tb/tb_viol_reset_seq.sv - directed table-driven bench for viol_reset_seq
module tb_viol_reset_seq;
   import viol_reset_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  viol;
   logic [15:0] pc;
   logic        sys_reset;
   logic [3:0]  cause;
   logic        cause_valid;
   logic [7:0]  reset_count;

   int checks;
   int failures;

   viol_reset_seq #(
      .NUM_SRC(4), .HOLD_CYCLES(16), .REL_TIMEOUT(255), .RESET_HANDLER(16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .viol        (viol),
      .pc          (pc),
      .sys_reset   (sys_reset),
      .cause       (cause),
      .cause_valid (cause_valid),
      .reset_count (reset_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] viol_in;
      logic [3:0] exp_cause;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // From a RUN cycle: pulse viol for one cycle, count sys_reset high cycles,
   // then take the RELEASE->RUN edge (pc must be at the handler).
   task automatic fire(input logic [3:0] v, output int hold);
      viol = v;
      tick();
      viol = 4'b0000;
      hold = 0;
      while (sys_reset && hold < 100) begin
         hold++;
         tick();
      end
      tick();
   endtask

   initial begin
      int hold;
      int rel;
      checks   = 0;
      failures = 0;
      rst  = 1'b1;
      viol = 4'b0000;
      pc   = 16'h0000;

      vecs[0] = '{4'b0100, 4'b0100, 8'd1};
      vecs[1] = '{4'b1001, 4'b1001, 8'd2};
      vecs[2] = '{4'b0001, 4'b0001, 8'd3};
      vecs[3] = '{4'b1111, 4'b1111, 8'd4};

      tick(); tick();
      check("rst_sys_reset", sys_reset, 1);
      check("rst_cause", cause, 0);
      check("rst_cause_valid", cause_valid, 0);
      check("rst_count", reset_count, 0);

      rst  = 1'b0;
      hold = 0;
      do begin
         tick();
         hold++;
      end while (sys_reset && hold < 100);
      check("initial_hold", hold, 16);
      tick();
      check("run_sys_reset", sys_reset, 0);
      check("run_cause_valid", cause_valid, 0);
      check("run_count", reset_count, 0);

      for (int i = 0; i < 4; i++) begin
         fire(vecs[i].viol_in, hold);
         check($sformatf("vec%0d_hold", i), hold, 16);
         check($sformatf("vec%0d_cause", i), cause, vecs[i].exp_cause);
         check($sformatf("vec%0d_valid", i), cause_valid, 1);
         check($sformatf("vec%0d_count", i), reset_count, vecs[i].exp_count);
      end

      // viol activity during ASSERT neither stretches the hold nor leaks into cause
      viol = 4'b0010;
      tick();
      hold = 0;
      while (sys_reset && hold < 100) begin
         viol = (hold < 12) ? 4'b1000 : 4'b0000;
         hold++;
         tick();
      end
      viol = 4'b0000;
      tick();
      check("assert_viol_hold", hold, 16);
      check("assert_viol_cause", cause, 4'b0010);
      check("assert_viol_count", reset_count, 5);

      // RELEASE timeout with pc stuck away from the handler
      viol = 4'b0001;
      tick();
      viol = 4'b0000;
      pc   = 16'h4400;
      hold = 0;
      while (sys_reset && hold < 100) begin
         hold++;
         tick();
      end
      check("timeout_first_hold", hold, 16);
      rel = 0;
      while (!sys_reset && rel < 400) begin
         viol = (rel >= 10 && rel < 20) ? 4'b0110 : 4'b0000;
         rel++;
         tick();
      end
      viol = 4'b0000;
      check("timeout_release_len", rel, 255);
      check("timeout_count", reset_count, 6);
      check("timeout_cause", cause, 4'b0001);
      pc   = 16'h0000;
      hold = 0;
      while (sys_reset && hold < 100) begin
         hold++;
         tick();
      end
      check("timeout_rehold", hold, 16);
      tick();

      for (int i = 0; i < 300; i++) begin
         fire(4'b0011, hold);
      end
      check("sat_hold", hold, 16);
      check("sat_count", reset_count, 255);
      check("sat_cause", cause, 4'b0011);

      // rst mid-RELEASE clears everything immediately
      viol = 4'b1000;
      tick();
      viol = 4'b0000;
      pc   = 16'h4400;
      hold = 0;
      while (sys_reset && hold < 100) begin
         hold++;
         tick();
      end
      tick(); tick(); tick();
      check("pre_rst_sys_reset", sys_reset, 0);
      check("pre_rst_count", reset_count, 255);
      #2;
      rst = 1'b1;
      #1;
      check("async_sys_reset", sys_reset, 1);
      check("async_cause", cause, 0);
      check("async_valid", cause_valid, 0);
      check("async_count", reset_count, 0);
      pc = 16'h0000;
      tick();
      rst  = 1'b0;
      hold = 0;
      do begin
         tick();
         hold++;
      end while (sys_reset && hold < 100);
      check("post_rst_hold", hold, 16);
      tick();
      fire(4'b0100, hold);
      check("post_rst_count", reset_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
